// File: rtl/region_select.sv
// region_select: keeps the largest-area candidate region of each frame and publishes it at frame end.
// Define REGION_SELECT_MEAN_EN to build the serial mean-gray divider; without it t_mean is constant 0.

module region_select #(
  parameter int MIN_AREA = 4,
  parameter int MAX_AREA = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fs,
  input  logic        e_valid,
  input  logic [9:0]  e_label,
  input  logic [8:0]  e_le,
  input  logic [8:0]  e_ri,
  input  logic [8:0]  e_upm,
  input  logic [8:0]  e_dw,
  input  logic [31:0] e_sum_gray,
  input  logic [19:0] e_num_gray,
  output logic        busy,
  output logic        t_valid,
  output logic [9:0]  t_label,
  output logic [8:0]  t_cx,
  output logic [8:0]  t_cy,
  output logic [8:0]  t_w,
  output logic [8:0]  t_h,
  output logic [7:0]  t_mean,
  output logic [19:0] t_area,
  output logic [7:0]  t_count,
  output logic [7:0]  t_drop
);

  localparam logic [19:0] MIN_A = 20'(MIN_AREA);
  localparam logic [19:0] MAX_A = 20'(MAX_AREA);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DIV   = 2'd2,
    CMP   = 2'd3
  } state_t;

  state_t      state_q;
  logic        fs_q;
  logic        pend_q;
  logic [9:0]  label_q;
  logic [8:0]  le_q, ri_q, upm_q, dw_q;
  logic [19:0] num_q;
  logic [7:0]  cnt_q;
  logic [7:0]  drop_q;

  logic [9:0]  best_label_q;
  logic [8:0]  best_cx_q, best_cy_q, best_w_q, best_h_q;
  logic [7:0]  best_mean_q;
  logic [19:0] best_area_q;

  logic        fs_rise_d, fs_fall_d, publish_d, cand_d;
  logic [8:0]  w_d, h_d, cx_d, cy_d;
  logic [7:0]  cur_mean_d;

  assign busy      = (state_q != IDLE);
  assign fs_rise_d = fs & ~fs_q;
  assign fs_fall_d = ~fs & fs_q;
  // A record arriving in the same cycle as the frame end is accepted first; publish waits for it.
  assign publish_d = (state_q == IDLE) && !e_valid && (pend_q || fs_fall_d);

  assign cand_d = (num_q >= MIN_A) && (num_q <= MAX_A) && (ri_q >= le_q) && (dw_q >= upm_q);
  assign w_d    = ri_q - le_q + 9'd1;
  assign h_d    = dw_q - upm_q + 9'd1;
  assign cx_d   = 9'(({1'b0, le_q} + {1'b0, ri_q}) >> 1);
  assign cy_d   = 9'(({1'b0, upm_q} + {1'b0, dw_q}) >> 1);

`ifdef REGION_SELECT_MEAN_EN
  logic [31:0] quo_q;
  logic [19:0] rem_q;
  logic [5:0]  it_q;
  logic [7:0]  mean_q;
  logic [20:0] shl_d;
  logic        ge_d;

  // Restoring division: the dividend shifts out of quo_q while quotient bits shift in.
  assign shl_d      = {rem_q, quo_q[31]};
  assign ge_d       = shl_d >= {1'b0, num_q};
  assign cur_mean_d = mean_q;
`else
  logic unused_sum;
  assign unused_sum = ^e_sum_gray;
  assign cur_mean_d = 8'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fs_q         <= 1'b0;
      pend_q       <= 1'b0;
      label_q      <= '0;
      le_q         <= '0;
      ri_q         <= '0;
      upm_q        <= '0;
      dw_q         <= '0;
      num_q        <= '0;
      cnt_q        <= '0;
      drop_q       <= '0;
      best_label_q <= '0;
      best_cx_q    <= '0;
      best_cy_q    <= '0;
      best_w_q     <= '0;
      best_h_q     <= '0;
      best_mean_q  <= '0;
      best_area_q  <= '0;
      t_valid      <= 1'b0;
      t_label      <= '0;
      t_cx         <= '0;
      t_cy         <= '0;
      t_w          <= '0;
      t_h          <= '0;
      t_mean       <= '0;
      t_area       <= '0;
      t_count      <= '0;
      t_drop       <= '0;
`ifdef REGION_SELECT_MEAN_EN
      quo_q        <= '0;
      rem_q        <= '0;
      it_q         <= '0;
      mean_q       <= '0;
`endif
    end else begin
      fs_q    <= fs;
      t_valid <= 1'b0;

      case (state_q)
        IDLE: begin
          if (e_valid) begin
            label_q <= e_label;
            le_q    <= e_le;
            ri_q    <= e_ri;
            upm_q   <= e_upm;
            dw_q    <= e_dw;
            num_q   <= e_num_gray;
`ifdef REGION_SELECT_MEAN_EN
            quo_q   <= e_sum_gray;
`endif
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (!cand_d) begin
            state_q <= IDLE;
          end else begin
`ifdef REGION_SELECT_MEAN_EN
            rem_q   <= '0;
            it_q    <= '0;
            state_q <= DIV;
`else
            state_q <= CMP;
`endif
          end
        end
`ifdef REGION_SELECT_MEAN_EN
        DIV: begin
          if (it_q != 6'd32) begin
            rem_q <= ge_d ? 20'(shl_d - {1'b0, num_q}) : 20'(shl_d);
            quo_q <= {quo_q[30:0], ge_d};
            it_q  <= it_q + 6'd1;
          end else begin
            mean_q  <= (|quo_q[31:8]) ? 8'hFF : quo_q[7:0];
            state_q <= CMP;
          end
        end
`endif
        CMP: begin
          if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
          // Strictly greater: on equal area the earlier record stays selected.
          if (num_q > best_area_q) begin
            best_label_q <= label_q;
            best_cx_q    <= cx_d;
            best_cy_q    <= cy_d;
            best_w_q     <= w_d;
            best_h_q     <= h_d;
            best_mean_q  <= cur_mean_d;
            best_area_q  <= num_q;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (e_valid && (state_q != IDLE) && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;

      if (fs_rise_d) begin
        cnt_q        <= '0;
        drop_q       <= '0;
        best_label_q <= '0;
        best_cx_q    <= '0;
        best_cy_q    <= '0;
        best_w_q     <= '0;
        best_h_q     <= '0;
        best_mean_q  <= '0;
        best_area_q  <= '0;
      end

      if (fs_fall_d) pend_q <= 1'b1;

      if (publish_d) begin
        pend_q  <= 1'b0;
        t_valid <= 1'b1;
        t_label <= best_label_q;
        t_cx    <= best_cx_q;
        t_cy    <= best_cy_q;
        t_w     <= best_w_q;
        t_h     <= best_h_q;
        t_mean  <= best_mean_q;
        t_area  <= best_area_q;
        t_count <= cnt_q;
        t_drop  <= drop_q;
      end
    end
  end

endmodule

// File: tb/tb_region_select.sv
// Directed and randomized frames for region_select, checked against a per-frame reference model
// that picks the winning region from the list of accepted records.

module tb_region_select;

  typedef struct {
    logic [9:0]  label;
    logic [8:0]  le, ri, upm, dw;
    logic [31:0] sum;
    logic [19:0] num;
  } rec_t;

`ifdef REGION_SELECT_MEAN_EN
  localparam bit MEAN_EN   = 1'b1;
  localparam int BUSY_CAND = 35;
`else
  localparam bit MEAN_EN   = 1'b0;
  localparam int BUSY_CAND = 2;
`endif

  logic        clk, rst_n, fs, e_valid;
  logic [9:0]  e_label;
  logic [8:0]  e_le, e_ri, e_upm, e_dw;
  logic [31:0] e_sum_gray;
  logic [19:0] e_num_gray;
  logic        busy, t_valid;
  logic [9:0]  t_label;
  logic [8:0]  t_cx, t_cy, t_w, t_h;
  logic [7:0]  t_mean;
  logic [19:0] t_area;
  logic [7:0]  t_count, t_drop;

  rec_t frame_q[$];
  int   exp_drop;
  int   passed, total;
  int   pulse_cnt;
  logic [9:0]  cap_label;
  logic [8:0]  cap_cx, cap_cy, cap_w, cap_h;
  logic [7:0]  cap_mean, cap_count, cap_drop;
  logic [19:0] cap_area;

  region_select dut (
    .clk(clk), .rst_n(rst_n), .fs(fs), .e_valid(e_valid), .e_label(e_label),
    .e_le(e_le), .e_ri(e_ri), .e_upm(e_upm), .e_dw(e_dw),
    .e_sum_gray(e_sum_gray), .e_num_gray(e_num_gray),
    .busy(busy), .t_valid(t_valid), .t_label(t_label), .t_cx(t_cx), .t_cy(t_cy),
    .t_w(t_w), .t_h(t_h), .t_mean(t_mean), .t_area(t_area),
    .t_count(t_count), .t_drop(t_drop)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobe monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (t_valid === 1'b1) begin
      pulse_cnt <= pulse_cnt + 1;
      cap_label <= t_label;
      cap_cx    <= t_cx;
      cap_cy    <= t_cy;
      cap_w     <= t_w;
      cap_h     <= t_h;
      cap_mean  <= t_mean;
      cap_area  <= t_area;
      cap_count <= t_count;
      cap_drop  <= t_drop;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit is_cand(input rec_t r);
    return (r.num >= 20'd4) && (r.num <= 20'd1024) && (r.ri >= r.le) && (r.dw >= r.upm);
  endfunction

  function automatic int busy_len(input rec_t r);
    return is_cand(r) ? BUSY_CAND : 1;
  endfunction

  function automatic rec_t mk(input int label, input int le, input int ri, input int upm,
                              input int dw, input logic [31:0] sum, input int num);
    rec_t r;
    r.label = 10'(label);
    r.le = 9'(le);
    r.ri = 9'(ri);
    r.upm = 9'(upm);
    r.dw = 9'(dw);
    r.sum = sum;
    r.num = 20'(num);
    return r;
  endfunction

  function automatic rec_t rand_rec();
    int le, ri, upm, dw, num;
    le  = $urandom_range(0, 511);
    upm = $urandom_range(0, 511);
    ri  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511) : $urandom_range(le, 511);
    dw  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511) : $urandom_range(upm, 511);
    case ($urandom_range(0, 5))
      0:       num = $urandom_range(0, 5);
      1:       num = $urandom_range(1000, 1100);
      default: num = $urandom_range(4, 1024);
    endcase
    return mk($urandom_range(0, 1023), le, ri, upm, dw, $urandom, num);
  endfunction

  // driver tasks
  task automatic drive(input rec_t r);
    e_label = r.label; e_le = r.le; e_ri = r.ri; e_upm = r.upm; e_dw = r.dw;
    e_sum_gray = r.sum; e_num_gray = r.num; e_valid = 1'b1;
  endtask

  task automatic send(input rec_t r);
    @(posedge clk); #1;
    drive(r);
    @(posedge clk); #1;
    e_valid = 1'b0;
  endtask

  task automatic send_acc(input rec_t r, input int extra);
    send(r);
    frame_q.push_back(r);
    tick(busy_len(r) - 1 + extra);
  endtask

  task automatic start_frame();
    @(posedge clk); #1;
    fs = 1'b1;
    frame_q.delete();
    exp_drop = 0;
    tick(2);
  endtask

  task automatic end_frame();
    @(posedge clk); #1;
    fs = 1'b0;
  endtask

  // scoreboard: model selects the winner over the frame's accepted records
  task automatic check_frame(input string tag);
    int best, cnt, base;
    longint q;
    logic [31:0] x_label, x_cx, x_cy, x_w, x_h, x_mean, x_area;
    best = -1; cnt = 0;
    x_label = 0; x_cx = 0; x_cy = 0; x_w = 0; x_h = 0; x_mean = 0; x_area = 0;
    foreach (frame_q[i]) begin
      if (is_cand(frame_q[i])) begin
        cnt = (cnt < 255) ? cnt + 1 : 255;
        if (best < 0 || frame_q[i].num > frame_q[best].num) best = i;
      end
    end
    if (best >= 0) begin
      x_label = 32'(frame_q[best].label);
      x_cx    = 32'((int'(frame_q[best].le) + int'(frame_q[best].ri)) / 2);
      x_cy    = 32'((int'(frame_q[best].upm) + int'(frame_q[best].dw)) / 2);
      x_w     = 32'((int'(frame_q[best].ri) - int'(frame_q[best].le) + 1) % 512);
      x_h     = 32'((int'(frame_q[best].dw) - int'(frame_q[best].upm) + 1) % 512);
      x_area  = 32'(frame_q[best].num);
      if (MEAN_EN) begin
        q = longint'(frame_q[best].sum) / longint'(frame_q[best].num);
        x_mean = (q > 255) ? 32'd255 : 32'(q);
      end
    end
    base = pulse_cnt;
    for (int i = 0; i < 400; i++) begin
      if (pulse_cnt != base) break;
      tick(1);
    end
    tick(3);
    chk({tag, ".strobes"}, 32'(pulse_cnt - base), 32'd1);
    chk({tag, ".label"}, 32'(cap_label), x_label);
    chk({tag, ".cx"}, 32'(cap_cx), x_cx);
    chk({tag, ".cy"}, 32'(cap_cy), x_cy);
    chk({tag, ".w"}, 32'(cap_w), x_w);
    chk({tag, ".h"}, 32'(cap_h), x_h);
    chk({tag, ".mean"}, 32'(cap_mean), x_mean);
    chk({tag, ".area"}, 32'(cap_area), x_area);
    chk({tag, ".count"}, 32'(cap_count), 32'(cnt));
    chk({tag, ".drop"}, 32'(cap_drop), 32'(exp_drop));
    chk({tag, ".hold_area"}, 32'(t_area), x_area);
    chk({tag, ".valid_low"}, 32'(t_valid), 32'd0);
    frame_q.delete();
    exp_drop = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".t_valid"}, 32'(t_valid), 32'd0);
    chk({tag, ".label"}, 32'(t_label), 32'd0);
    chk({tag, ".cx"}, 32'(t_cx), 32'd0);
    chk({tag, ".cy"}, 32'(t_cy), 32'd0);
    chk({tag, ".w"}, 32'(t_w), 32'd0);
    chk({tag, ".h"}, 32'(t_h), 32'd0);
    chk({tag, ".mean"}, 32'(t_mean), 32'd0);
    chk({tag, ".area"}, 32'(t_area), 32'd0);
    chk({tag, ".count"}, 32'(t_count), 32'd0);
    chk({tag, ".drop"}, 32'(t_drop), 32'd0);
  endtask

  task automatic busy_len_check(input string tag, input rec_t r);
    int n;
    send(r);
    frame_q.push_back(r);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy !== 1'b1) break;
      n++;
      tick(1);
    end
    chk(tag, 32'(n), 32'(busy_len(r)));
  endtask

  initial begin
    rec_t r1, r2;
    int base, nrec;
    passed = 0; total = 0; pulse_cnt = 0; exp_drop = 0;
    rst_n = 1'b0; fs = 1'b0; e_valid = 1'b0;
    e_label = '0; e_le = '0; e_ri = '0; e_upm = '0; e_dw = '0; e_sum_gray = '0; e_num_gray = '0;
    tick(3);
    chk_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // single record
    start_frame();
    send_acc(mk(5, 4, 11, 2, 9, 32'd6400, 64), 1);
    end_frame();
    check_frame("single");

    // area 3 rejected, equal areas keep the earlier label
    start_frame();
    send_acc(mk(1, 0, 2, 0, 0, 32'd300, 3), 0);
    send_acc(mk(2, 10, 19, 20, 24, 32'd5000, 50), 2);
    send_acc(mk(3, 30, 34, 40, 49, 32'd1000, 50), 0);
    end_frame();
    check_frame("tie");

    // busy duration for candidate and rejected records
    start_frame();
    busy_len_check("busy_cand", mk(7, 100, 140, 50, 60, 32'd77777, 400));
    busy_len_check("busy_rej", mk(8, 100, 90, 50, 60, 32'd100, 400));
    end_frame();
    check_frame("busy_frame");

    // record arriving while busy is dropped; the first one still counts
    start_frame();
    r1 = mk(9, 20, 40, 20, 40, 32'd90000, 441);
    send(r1);
    frame_q.push_back(r1);
    send(mk(10, 0, 511, 0, 511, 32'd1, 1000));
    exp_drop = 1;
    tick(BUSY_CAND);
    end_frame();
    check_frame("drop");

    // empty frame clears counters and best
    start_frame();
    end_frame();
    check_frame("empty");

    // mean saturation and a zero-area record
    start_frame();
    send_acc(mk(11, 1, 2, 1, 2, 32'h0001_0000, 4), 0);
    send_acc(mk(12, 1, 300, 1, 300, 32'd0, 0), 0);
    end_frame();
    check_frame("saturate");

    // frame ends while a record is in flight
    start_frame();
    r1 = mk(13, 200, 260, 100, 131, 32'd123456, 900);
    send(r1);
    frame_q.push_back(r1);
    fs = 1'b0;
    check_frame("late_fall");

    // record coincident with the frame end is included
    start_frame();
    send_acc(mk(14, 5, 6, 5, 6, 32'd40, 4), 0);
    r2 = mk(15, 50, 99, 60, 69, 32'd250000, 500);
    @(posedge clk); #1;
    drive(r2);
    fs = 1'b0;
    frame_q.push_back(r2);
    @(posedge clk); #1;
    e_valid = 1'b0;
    check_frame("coincident");

    // reset while a frame result is pending abandons it
    start_frame();
    r1 = mk(16, 10, 300, 10, 300, 32'd999999, 800);
    @(posedge clk); #1;
    drive(r1);
    @(posedge clk); #1;
    e_valid = 1'b0;
    fs = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    base = pulse_cnt;
    tick(2);
    rst_n = 1'b1;
    tick(40);
    chk("mid_reset.no_strobe", 32'(pulse_cnt - base), 32'd0);
    frame_q.delete();

    // randomized frames
    for (int f = 0; f < 8; f++) begin
      start_frame();
      nrec = $urandom_range(1, 6);
      for (int k = 0; k < nrec; k++) begin
        r1 = rand_rec();
        if (is_cand(r1) && $urandom_range(0, 3) == 0) begin
          send(r1);
          frame_q.push_back(r1);
          send(rand_rec());
          exp_drop++;
          tick(BUSY_CAND + $urandom_range(0, 2));
        end else begin
          send_acc(r1, $urandom_range(0, 3));
        end
      end
      end_frame();
      check_frame($sformatf("rand%0d", f));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
